mul_share_arbiter: RTL and testbench

Shares one cv32e40p multiplier (cv32e40p_mult) between NUM_REQ independent requesters, e.g. the core EX stage and a DSP/accelerator port.
- Round-robin arbitration; exactly one operation in flight at a time.
- Sequences single-cycle and multicycle (MUL_H) operations through the multiplier's enable/ready/ex_ready protocol.
- Returns the result to the owning requester over a valid/ready response channel.
- A watchdog bounds every operation.

---
 rtl/cv32e40p_pkg.sv | 14 +
 rtl/mul_share_arbiter_pkg.sv | 21 ++
 rtl/mul_share_arbiter_if.sv | 26 ++
 rtl/mul_share_arbiter_rr.sv | 30 +++
 rtl/mul_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_mul_share_arbiter.sv | 243 ++++++++++++++++++++++++
 6 files changed

// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - multiplier opcode subset of the cv32e40p core package
package cv32e40p_pkg;

   typedef enum logic [2:0] {
      MUL_MAC32 = 3'b000,
      MUL_MSU32 = 3'b001,
      MUL_I     = 3'b010,
      MUL_IR    = 3'b011,
      MUL_DOT8  = 3'b100,
      MUL_DOT16 = 3'b101,
      MUL_H     = 3'b110
   } mul_opcode_e;

endpackage

// File: rtl/mul_share_arbiter_pkg.sv
// rtl/mul_share_arbiter_pkg.sv - types and defaults for the shared multiplier arbiter
package mul_arb_pkg;

   localparam int unsigned MUL_ARB_NUM_REQ = 2;
   localparam int unsigned MUL_ARB_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } mul_arb_state_e;

   typedef struct packed {
      cv32e40p_pkg::mul_opcode_e op;
      logic [1:0]                short_signed;
      logic [31:0]               a;
      logic [31:0]               b;
      logic [31:0]               c;
   } mul_req_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - bus between the arbiter and the cv32e40p multiplier
interface mul_share_arbiter_if;
   import cv32e40p_pkg::*;

   logic        enable;
   mul_opcode_e operator;
   logic [1:0]  short_signed;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] op_c;
   logic        ex_ready;
   logic [31:0] result;
   logic        ready;
   logic        multicycle;

   modport master (
      output enable, operator, short_signed, op_a, op_b, op_c, ex_ready,
      input  result, ready, multicycle
   );

   modport slave (
      input  enable, operator, short_signed, op_a, op_b, op_c, ex_ready,
      output result, ready, multicycle
   );

endinterface

// File: rtl/mul_share_arbiter_rr.sv
// rtl/mul_share_arbiter_rr.sv - combinational round-robin one-hot grant
module mul_rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned PW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [PW-1:0]      rr_ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [PW-1:0]      grant_idx_o
);

   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = '0;
      // Scan starting at the pointer so the last owner has lowest priority.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = PW'((32'(rr_ptr_i) + i) % NUM_REQ);
         if (!found && valid_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - shares one cv32e40p multiplier among NUM_REQ requesters
module mul_share_arbiter
   import mul_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = MUL_ARB_NUM_REQ,
   parameter int unsigned TIMEOUT = MUL_ARB_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ-1:0][2:0]  req_op_i,
   input  logic [NUM_REQ-1:0][1:0]  req_short_signed_i,
   input  logic [NUM_REQ-1:0][31:0] req_op_a_i,
   input  logic [NUM_REQ-1:0][31:0] req_op_b_i,
   input  logic [NUM_REQ-1:0][31:0] req_op_c_i,
   output logic [NUM_REQ-1:0]       rsp_valid_o,
   input  logic [NUM_REQ-1:0]       rsp_ready_i,
   output logic [31:0]              rsp_result_o,
   output logic                     rsp_err_o,
   mul_share_arbiter_if.master      mul
);

   localparam int unsigned PW = $clog2(NUM_REQ);
   localparam int unsigned WW = $clog2(TIMEOUT);

   mul_arb_state_e state_q, state_d;
   logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]  owner_q, owner_d;
   mul_req_t       req_q, req_d;
   logic [31:0]    result_q, result_d;
   logic           err_q, err_d;
   logic [WW-1:0]  wd_cnt_q, wd_cnt_d;

   logic [NUM_REQ-1:0] grant;
   logic [PW-1:0]      grant_idx;

   mul_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .valid_i     (req_valid_i),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         req_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         wd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         req_q    <= req_d;
         result_q <= result_d;
         err_q    <= err_d;
         wd_cnt_q <= wd_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      req_d    = req_q;
      result_d = result_q;
      err_d    = err_q;
      wd_cnt_d = wd_cnt_q;
      case (state_q)
         IDLE: begin
            if (|req_valid_i) begin
               owner_d            = grant_idx;
               req_d.op           = cv32e40p_pkg::mul_opcode_e'(req_op_i[grant_idx]);
               req_d.short_signed = req_short_signed_i[grant_idx];
               req_d.a            = req_op_a_i[grant_idx];
               req_d.b            = req_op_b_i[grant_idx];
               req_d.c            = req_op_c_i[grant_idx];
               wd_cnt_d           = '0;
               state_d            = EXEC;
            end
         end
         EXEC: begin
            // A late ready on the watchdog's last cycle still completes normally.
            if (mul.ready) begin
               result_d = mul.result;
               err_d    = 1'b0;
               state_d  = RESP;
            end else if (wd_cnt_q == WW'(TIMEOUT - 1)) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = RESP;
            end else begin
               wd_cnt_d = wd_cnt_q + WW'(1);
            end
         end
         RESP: begin
            if (rsp_ready_i[owner_q]) begin
               rr_ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o      = '0;
      rsp_valid_o      = '0;
      rsp_result_o     = '0;
      rsp_err_o        = 1'b0;
      mul.enable       = 1'b0;
      mul.ex_ready     = 1'b0;
      mul.operator     = cv32e40p_pkg::MUL_MAC32;
      mul.short_signed = '0;
      mul.op_a         = '0;
      mul.op_b         = '0;
      mul.op_c         = '0;
      case (state_q)
         IDLE: req_ready_o = grant;
         EXEC: begin
            mul.enable       = 1'b1;
            mul.ex_ready     = 1'b1;
            mul.operator     = req_q.op;
            mul.short_signed = req_q.short_signed;
            mul.op_a         = req_q.a;
            mul.op_b         = req_q.b;
            mul.op_c         = req_q.c;
         end
         RESP: begin
            rsp_valid_o  = NUM_REQ'(1) << owner_q;
            rsp_result_o = result_q;
            rsp_err_o    = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;
   import cv32e40p_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid, req_ready;
   logic [1:0][2:0]  req_op;
   logic [1:0][1:0]  req_ss;
   logic [1:0][31:0] req_a, req_b, req_c;
   logic [1:0]       rsp_valid, rsp_ready;
   logic [31:0]      rsp_result;
   logic             rsp_err;
   logic             stall;
   logic [2:0]       hcnt;

   int n_cmp, n_mis;
   int en, lat, ng;
   logic grants [4];

   mul_share_arbiter_if mb ();

   mul_share_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid_i        (req_valid),
      .req_ready_o        (req_ready),
      .req_op_i           (req_op),
      .req_short_signed_i (req_ss),
      .req_op_a_i         (req_a),
      .req_op_b_i         (req_b),
      .req_op_c_i         (req_c),
      .rsp_valid_o        (rsp_valid),
      .rsp_ready_i        (rsp_ready),
      .rsp_result_o       (rsp_result),
      .rsp_err_o          (rsp_err),
      .mul                (mb)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mul_model(logic [2:0] op, logic [1:0] ss,
                                             logic [31:0] a, logic [31:0] b, logic [31:0] c);
      logic [63:0] ea, eb, p;
      ea = {{32{ss[0] & a[31]}}, a};
      eb = {{32{ss[1] & b[31]}}, b};
      p  = ea * eb;
      if (op == 3'b110) return p[63:32];
      return a * b + c;
   endfunction

   // Multiplier stand-in: single-cycle ops are ready at once, MUL_H after 5 enabled cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) hcnt <= '0;
      else if (mb.enable && mb.operator == MUL_H && !mb.ready) hcnt <= hcnt + 3'd1;
      else hcnt <= '0;
   end
   assign mb.ready      = mb.enable && !stall && (mb.operator != MUL_H || hcnt == 3'd4);
   assign mb.multicycle = mb.enable && mb.operator == MUL_H && !mb.ready;
   assign mb.result     = mul_model(mb.operator, mb.short_signed, mb.op_a, mb.op_b, mb.op_c);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic idx, input logic [2:0] op, input logic [1:0] ss,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         output int en_cyc, output int lat_cyc);
      req_valid      = 2'b00;
      req_valid[idx] = 1'b1;
      req_op[idx]    = op;
      req_ss[idx]    = ss;
      req_a[idx]     = a;
      req_b[idx]     = b;
      req_c[idx]     = c;
      #1;
      chk("accept_ready", req_ready, 2'b01 << idx);
      @(posedge clk); #1;
      req_valid = 2'b00;
      en_cyc  = 0;
      lat_cyc = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         lat_cyc++;
         if (k == 0) chk("exec_op_a_passthru", mb.op_a, a);
         if (mb.enable) en_cyc++;
         if (rsp_valid != 2'b00) break;
      end
   endtask

   task automatic release_rsp(input logic idx);
      rsp_ready = 2'b01 << idx;
      @(posedge clk); #1;
      rsp_ready = 2'b00;
      @(negedge clk);
      chk("release_rsp_valid", rsp_valid, 2'b00);
   endtask

   initial begin
      n_cmp = 0; n_mis = 0;
      rst_n = 1'b0; stall = 1'b0;
      req_valid = '0; req_op = '0; req_ss = '0;
      req_a = '0; req_b = '0; req_c = '0; rsp_ready = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mul_enable", mb.enable, 0);
      chk("rst_ex_ready", mb.ex_ready, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_op_a", mb.op_a, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single-cycle MAC32 on requester 0
      run_op(1'b0, MUL_MAC32, 2'b00, 32'd7, 32'd6, 32'd0, en, lat);
      chk("t1_en_cycles", en, 1);
      chk("t1_latency", lat, 2);
      chk("t1_rsp_valid", rsp_valid, 2'b01);
      chk("t1_result", rsp_result, 32'h0000002A);
      chk("t1_err", rsp_err, 0);
      release_rsp(1'b0);

      // multicycle MUL_H on requester 1
      run_op(1'b1, MUL_H, 2'b11, 32'h80000000, 32'd2, 32'd0, en, lat);
      chk("t2_en_cycles", en, 5);
      chk("t2_latency", lat, 6);
      chk("t2_rsp_valid", rsp_valid, 2'b10);
      chk("t2_result", rsp_result, 32'hFFFFFFFF);
      chk("t2_err", rsp_err, 0);
      release_rsp(1'b1);

      // both requesters continuously valid
      req_op = '0; req_ss = '0;
      req_a[0] = 32'd3;  req_b[0] = 32'd5;  req_c[0] = 32'd1;
      req_a[1] = 32'd10; req_b[1] = 32'd10; req_c[1] = 32'd5;
      rsp_ready = 2'b11; req_valid = 2'b11; ng = 0;
      for (int k = 0; k < 30; k++) begin
         #1;
         if (req_ready != 2'b00) begin
            grants[ng] = (req_ready == 2'b10);
            ng++;
         end
         if (mb.enable) chk("t3_no_grant_exec", req_ready, 0);
         if (rsp_valid != 2'b00) begin
            chk("t3_no_grant_resp", req_ready, 0);
            chk("t3_result", rsp_result, rsp_valid[1] ? 32'h69 : 32'h10);
         end
         if (ng == 4) break;
         @(negedge clk);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      rsp_ready = 2'b00;
      chk("t3_grant_count", ng, 4);
      if (ng == 4) begin
         chk("t3_grant0", grants[0], 0);
         chk("t3_grant1", grants[1], 1);
         chk("t3_grant2", grants[2], 0);
         chk("t3_grant3", grants[3], 1);
      end
      chk("t3_idle", rsp_valid, 0);

      // response back-pressure with owner re-requesting
      run_op(1'b0, MUL_MAC32, 2'b00, 32'h12345678, 32'd2, 32'd1, en, lat);
      chk("t4_result", rsp_result, 32'h2468ACF1);
      req_valid = 2'b01; rsp_ready = 2'b10;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t4_hold_valid", rsp_valid, 2'b01);
         chk("t4_hold_result", rsp_result, 32'h2468ACF1);
         chk("t4_hold_err", rsp_err, 0);
         chk("t4_no_accept", req_ready, 0);
         @(negedge clk);
      end
      rsp_ready = 2'b01;
      @(posedge clk); #1;
      rsp_ready = 2'b00;
      @(negedge clk);
      chk("t4_after_hs_valid", rsp_valid, 0);
      chk("t4_after_hs_ready", req_ready, 2'b01);
      req_valid = 2'b00;
      #1;
      chk("t4_drop_ready", req_ready, 0);
      @(negedge clk);

      // watchdog timeout, then a normal operation
      stall = 1'b1;
      run_op(1'b0, MUL_MAC32, 2'b00, 32'd5, 32'd5, 32'd0, en, lat);
      chk("t5_en_cycles", en, 16);
      chk("t5_latency", lat, 17);
      chk("t5_rsp_valid", rsp_valid, 2'b01);
      chk("t5_result", rsp_result, 0);
      chk("t5_err", rsp_err, 1);
      release_rsp(1'b0);
      stall = 1'b0;
      run_op(1'b1, MUL_MAC32, 2'b00, 32'd9, 32'd9, 32'd1, en, lat);
      chk("t5_next_latency", lat, 2);
      chk("t5_next_result", rsp_result, 32'h00000052);
      chk("t5_next_err", rsp_err, 0);
      release_rsp(1'b1);

      // reset during the third EXEC cycle of MUL_H
      run_op(1'b0, MUL_MAC32, 2'b00, 32'd1, 32'd1, 32'd0, en, lat);
      chk("t6_pre_result", rsp_result, 32'd1);
      release_rsp(1'b0);
      req_op[1] = MUL_H; req_ss[1] = 2'b00; req_a[1] = 32'd4; req_b[1] = 32'd4;
      req_valid = 2'b11;
      #1;
      chk("t6_grant_ptr1", req_ready, 2'b10);
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      chk("t6_exec3_enable", mb.enable, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_enable", mb.enable, 0);
      chk("t6_rst_ex_ready", mb.ex_ready, 0);
      chk("t6_rst_op_a", mb.op_a, 0);
      chk("t6_rst_rsp_valid", rsp_valid, 0);
      chk("t6_rst_req_ready", req_ready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t6_no_spurious_rsp", rsp_valid, 0);
      end
      req_valid = 2'b11;
      #1;
      chk("t6_grant_ptr0", req_ready, 2'b01);
      req_valid = 2'b00;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
